object_detection: RTL and testbench

- Pixel-vs-rectangle hit test for the VGA display path.
- Each cycle the scan position (x_pos = line/row axis, y_pos = column axis) is compared against one axis-aligned object box.
- The box has origin (Px, Py), extent H along x and W along y.
- Registered `detected` output feeds the colour mux / sprite layer one cycle later.

---
 rtl/vga_pkg.sv | 19 +
 rtl/range_check.sv | 37 +++
 rtl/object_detection.sv | 91 +++++++++
 tb/tb_object_detection.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared VGA display-path constants and coordinate types.
//   H_VISIBLE / V_VISIBLE : visible columns / rows of the raster.
//   XW / YW               : bit widths of the row (x) and column (y) coordinates.
//   row_t / col_t         : coordinate types for the row and column axes.
// -----------------------------------------------------------------------------
package vga_pkg;

    localparam int H_VISIBLE = 640;
    localparam int V_VISIBLE = 480;

    localparam int XW = 9;   // row axis, 0..479 visible
    localparam int YW = 10;  // column axis, 0..639 visible

    typedef logic [XW-1:0] row_t;
    typedef logic [YW-1:0] col_t;

endpackage

// File: rtl/range_check.sv
// -----------------------------------------------------------------------------
// range_check
// Half-open interval test on one axis: origin <= pos < origin + extent.
// Ports:
//   pos, origin, extent : N-bit coordinate, interval start and interval length.
//   in_range            : pos lies inside the interval.
//   first               : pos == origin.
//   last                : pos == origin + extent - 1.
// The end point is formed at N+1 bits, so an interval running past the top of
// the coordinate range is clipped rather than wrapping back to 0. A zero extent
// makes the end equal the origin, so in_range can never be true.
// -----------------------------------------------------------------------------
module range_check #(
    parameter int N = 9
) (
    input  logic [N-1:0] pos,
    input  logic [N-1:0] origin,
    input  logic [N-1:0] extent,
    output logic         in_range,
    output logic         first,
    output logic         last
);

    logic [N:0] pos_ext;
    logic [N:0] end_ext;
    logic [N:0] last_ext;

    always_comb begin
        pos_ext  = {1'b0, pos};
        end_ext  = {1'b0, origin} + {1'b0, extent};
        last_ext = end_ext - {{N{1'b0}}, 1'b1};
        in_range = (pos >= origin) && (pos_ext < end_ext);
        first    = (pos == origin);
        last     = (pos_ext == last_ext);
    end

endmodule

// File: rtl/object_detection.sv
// -----------------------------------------------------------------------------
// object_detection
// Pixel-vs-rectangle hit test for the VGA display path. The current scan
// position is compared each cycle with one axis-aligned box and the result is
// registered, so `detected` describes the position presented one edge earlier.
// Ports:
//   clk, rst       : clock (rising edge), synchronous active-high reset.
//   x_pos, y_pos   : scan row / scan column.
//   Px, Py         : box origin (row axis top, column axis left).
//   H, W           : box extent along row axis / column axis.
//   detected       : registered hit flag.
//   border         : registered one-pixel box outline flag; present only when
//                    OBJECT_DETECTION_BORDER_EN is defined.
// Box parameters are used directly each cycle (no shadow registers).
// -----------------------------------------------------------------------------
module object_detection #(
    parameter int XW = vga_pkg::XW,
    parameter int YW = vga_pkg::YW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [XW-1:0] x_pos,
    input  logic [YW-1:0] y_pos,
    input  logic [XW-1:0] Px,
    input  logic [YW-1:0] Py,
    input  logic [YW-1:0] W,
    input  logic [XW-1:0] H,
`ifdef OBJECT_DETECTION_BORDER_EN
    output logic          border,
`endif
    output logic          detected
);

    import vga_pkg::*;

    logic x_in, x_first, x_last;
    logic y_in, y_first, y_last;
    logic hit;
    logic detected_d, detected_q;

    range_check #(.N(XW)) u_x_range (
        .pos      (x_pos),
        .origin   (Px),
        .extent   (H),
        .in_range (x_in),
        .first    (x_first),
        .last     (x_last)
    );

    range_check #(.N(YW)) u_y_range (
        .pos      (y_pos),
        .origin   (Py),
        .extent   (W),
        .in_range (y_in),
        .first    (y_first),
        .last     (y_last)
    );

    always_comb begin
        hit        = x_in && y_in;
        detected_d = hit;
    end

    always_ff @(posedge clk) begin
        if (rst) detected_q <= 1'b0;
        else     detected_q <= detected_d;
    end

    assign detected = detected_q;

`ifdef OBJECT_DETECTION_BORDER_EN
    logic border_d, border_q;

    // Outline pixel: inside the box and on any of its four edges.
    always_comb begin
        border_d = hit && (x_first || x_last || y_first || y_last);
    end

    always_ff @(posedge clk) begin
        if (rst) border_q <= 1'b0;
        else     border_q <= border_d;
    end

    assign border = border_q;
`else
    // Edge flags only feed the outline overlay.
    logic unused_edges;
    assign unused_edges = &{1'b0, x_first, x_last, y_first, y_last};
`endif

endmodule

// File: tb/tb_object_detection.sv
module tb_object_detection;

    localparam int XW = 9;
    localparam int YW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic [XW-1:0] x_pos, Px, H;
    logic [YW-1:0] y_pos, Py, W;
    logic          detected;
`ifdef OBJECT_DETECTION_BORDER_EN
    logic          border;
`endif

    int checks = 0;
    int errors = 0;

    object_detection #(.XW(XW), .YW(YW)) dut (
        .clk      (clk),
        .rst      (rst),
        .x_pos    (x_pos),
        .y_pos    (y_pos),
        .Px       (Px),
        .Py       (Py),
        .W        (W),
        .H        (H),
`ifdef OBJECT_DETECTION_BORDER_EN
        .border   (border),
`endif
        .detected (detected)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic, so box ends never wrap.
    function automatic int ref_hit(int x, int y, int px, int py, int w, int h);
        return (x >= px && x < px + h && y >= py && y < py + w) ? 1 : 0;
    endfunction

    function automatic int ref_border(int x, int y, int px, int py, int w, int h);
        if (ref_hit(x, y, px, py, w, h) == 0) return 0;
        return (x == px || x == px + h - 1 || y == py || y == py + w - 1) ? 1 : 0;
    endfunction

    task automatic set_box(input int px, input int py, input int w, input int h);
        Px = px[XW-1:0]; Py = py[YW-1:0]; W = w[YW-1:0]; H = h[XW-1:0];
    endtask

    // Present one position, clock it in, then sample just after the edge.
    task automatic step(input int x, input int y);
        x_pos = x[XW-1:0];
        y_pos = y[YW-1:0];
        @(posedge clk);
        #1;
    endtask

    task automatic step_chk(input string tag, input int x, input int y);
        step(x, y);
        chk(tag, int'(detected), rst ? 0 : ref_hit(x, y, Px, Py, W, H));
`ifdef OBJECT_DETECTION_BORDER_EN
        chk({tag, "_border"}, int'(border), rst ? 0 : ref_border(x, y, Px, Py, W, H));
`endif
    endtask

    initial begin
        int hits, bad_cycles;
        rst = 1'b1;
        set_box(10, 10, 10, 10);
        x_pos = '0; y_pos = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", int'(detected), 0);
        rst = 1'b0;

        // Directed points on a 10/10/10/10 box.
        step_chk("origin", 10, 10);
        chk("origin_const", int'(detected), 1);
        step_chk("far_corner", 19, 19);
        chk("far_corner_const", int'(detected), 1);
        step_chk("left_out", 15, 9);
        chk("left_out_const", int'(detected), 0);
        step_chk("x_end_excl", 20, 15);
        chk("x_end_excl_const", int'(detected), 0);
        step_chk("y_end_excl", 15, 20);
        chk("y_end_excl_const", int'(detected), 0);
        step_chk("top_out", 9, 15);
        chk("top_out_const", int'(detected), 0);

        // Raster sweep over the rows holding the box (rows outside cannot hit).
        hits = 0; bad_cycles = 0;
        for (int x = 0; x < 40; x++)
            for (int y = 0; y < 640; y++) begin
                step(x, y);
                if (detected) hits++;
                if (int'(detected) != ref_hit(x, y, 10, 10, 10, 10)) bad_cycles++;
            end
        chk("sweep_hits", hits, 100);
        chk("sweep_alignment", bad_cycles, 0);

        // Box past the bottom edge of the row range: clipped, not wrapped.
        set_box(500, 0, 640, 20);
        step_chk("clip_in", 510, 100);
        chk("clip_in_const", int'(detected), 1);
        step_chk("clip_wrap", 5, 100);
        chk("clip_wrap_const", int'(detected), 0);
        step_chk("clip_top", 511, 639);

        // Zero extent on the row axis: strided frame sweep must never hit.
        set_box(10, 10, 10, 0);
        hits = 0;
        for (int x = 0; x < 480; x += 16)
            for (int y = 0; y < 640; y++) begin
                step(x, y);
                if (detected) hits++;
            end
        step(10, 15);
        if (detected) hits++;
        chk("zero_extent_hits", hits, 0);
        set_box(10, 10, 0, 10);
        step_chk("zero_w", 10, 10);

        // Reset while inside the box, then release.
        set_box(10, 10, 10, 10);
        rst = 1'b1;
        step_chk("rst_inside", 12, 12);
        chk("rst_inside_const", int'(detected), 0);
        rst = 1'b0;
        step_chk("rst_release", 12, 12);
        chk("rst_release_const", int'(detected), 1);
`ifdef OBJECT_DETECTION_BORDER_EN
        step_chk("edge_px", 10, 15);
        chk("edge_px_border", int'(border), 1);
        step_chk("center", 15, 15);
        chk("center_border", int'(border), 0);
`endif

        // Random boxes with positions clustered around them.
        for (int i = 0; i < 400; i++) begin
            int px, py, w, h, x, y;
            px = $urandom_range(511, 0);
            py = $urandom_range(1023, 0);
            h  = $urandom_range(12, 0);
            w  = $urandom_range(12, 0);
            if (i % 5 == 0) begin
                h = $urandom_range(511, 0);
                w = $urandom_range(1023, 0);
            end
            set_box(px, py, w, h);
            x = px + $urandom_range(16, 0) - 2;
            y = py + $urandom_range(16, 0) - 2;
            if (x < 0) x = 0;
            if (x > 511) x = 511;
            if (y < 0) y = 0;
            if (y > 1023) y = 1023;
            rst = ($urandom_range(19, 0) == 0);
            step_chk("random", x, y);
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
